// File: rtl/rf_writeback_ctrl.sv
// rf_writeback_ctrl
// Writeback stage for a 2R/2W register file. ALU results go to port A and
// post-increment address updates go to port B. Load returns are held in an
// in-order tracking queue and are drained onto whichever port is free. A
// busy scoreboard flags read addresses that still have a load outstanding.
module rf_writeback_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int LD_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid_i,
  input  logic [ADDR_WIDTH-1:0] alu_waddr_i,
  input  logic [DATA_WIDTH-1:0] alu_wdata_i,
  input  logic                  pinc_valid_i,
  input  logic [ADDR_WIDTH-1:0] pinc_waddr_i,
  input  logic [DATA_WIDTH-1:0] pinc_wdata_i,
  input  logic                  ld_issue_i,
  input  logic [ADDR_WIDTH-1:0] ld_waddr_i,
  output logic                  ld_issue_ready_o,
  input  logic                  ld_rvalid_i,
  input  logic [DATA_WIDTH-1:0] ld_rdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  output logic                  busy_a_o,
  output logic                  busy_b_o,
  output logic [ADDR_WIDTH-1:0] waddr_a_o,
  output logic [DATA_WIDTH-1:0] wdata_a_o,
  output logic                  we_a_o,
  output logic [ADDR_WIDTH-1:0] waddr_b_o,
  output logic [DATA_WIDTH-1:0] wdata_b_o,
  output logic                  we_b_o,
  output logic                  ld_err_o
);

  localparam int PTR_W = $clog2(LD_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Per-entry queue storage
  logic [ADDR_WIDTH-1:0] tag_q    [LD_DEPTH];
  logic [DATA_WIDTH-1:0] data_q   [LD_DEPTH];
  logic                  alloc_q  [LD_DEPTH];
  logic                  filled_q [LD_DEPTH];

  // Pointers, occupancy and sticky error
  logic [PTR_W-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [PTR_W-1:0] fill_ptr_q, fill_ptr_d;
  logic [PTR_W-1:0] drain_ptr_q, drain_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  // Per-cycle events
  logic issue_ok;
  logic fill_ok;
  logic head_rdy;
  logic drain_a;
  logic drain_b;
  logic drain;

  // Scoreboard match vectors
  logic [LD_DEPTH-1:0] hit_a;
  logic [LD_DEPTH-1:0] hit_b;

  assign ld_issue_ready_o = (count_q < CNT_W'(LD_DEPTH));
  assign ld_err_o         = err_q;

  // Decide which queue events take effect this cycle. Filled is a registered
  // flag, so a load returned this cycle can only drain from the next cycle on.
  always_comb begin
    issue_ok = ld_issue_i && ld_issue_ready_o;
    fill_ok  = ld_rvalid_i && alloc_q[fill_ptr_q] && !filled_q[fill_ptr_q];
    head_rdy = alloc_q[drain_ptr_q] && filled_q[drain_ptr_q];
    drain_a  = head_rdy && !alu_valid_i;
    drain_b  = head_rdy && alu_valid_i && !pinc_valid_i;
    drain    = drain_a || drain_b;
  end

  // Next pointers, occupancy and error flag
  always_comb begin
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    drain_ptr_d = drain_ptr_q;
    count_d     = count_q;
    err_d       = err_q;
    if (issue_ok) alloc_ptr_d = alloc_ptr_q + 1'b1;
    if (fill_ok)  fill_ptr_d  = fill_ptr_q + 1'b1;
    if (drain)    drain_ptr_d = drain_ptr_q + 1'b1;
    if (issue_ok && !drain)      count_d = count_q + 1'b1;
    else if (!issue_ok && drain) count_d = count_q - 1'b1;
    if ((ld_issue_i && !ld_issue_ready_o) || (ld_rvalid_i && !fill_ok)) err_d = 1'b1;
  end

  // Pointer, count and error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      drain_ptr_q <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      drain_ptr_q <= drain_ptr_d;
      count_q     <= count_d;
      err_q       <= err_d;
    end
  end

  // Queue entries: issue, fill and drain always address distinct entries,
  // so all three can be applied in the same cycle without conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LD_DEPTH; i++) begin
        tag_q[i]    <= '0;
        data_q[i]   <= '0;
        alloc_q[i]  <= 1'b0;
        filled_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < LD_DEPTH; i++) begin
        if (issue_ok && (alloc_ptr_q == PTR_W'(i))) begin
          tag_q[i]    <= ld_waddr_i;
          alloc_q[i]  <= 1'b1;
          filled_q[i] <= 1'b0;
        end else if (drain && (drain_ptr_q == PTR_W'(i))) begin
          alloc_q[i]  <= 1'b0;
          filled_q[i] <= 1'b0;
        end
        if (fill_ok && (fill_ptr_q == PTR_W'(i))) begin
          data_q[i]   <= ld_rdata_i;
          filled_q[i] <= 1'b1;
        end
      end
    end
  end

  // Scoreboard: an allocated entry stays busy through its drain cycle
  for (genvar gi = 0; gi < LD_DEPTH; gi++) begin : g_sb
    assign hit_a[gi] = alloc_q[gi] && (tag_q[gi] == raddr_a_i);
    assign hit_b[gi] = alloc_q[gi] && (tag_q[gi] == raddr_b_i);
  end
  assign busy_a_o = |hit_a;
  assign busy_b_o = |hit_b;

  // Write-port muxing; idle ports drive zero address and data
  always_comb begin
    we_a_o    = 1'b0;
    waddr_a_o = '0;
    wdata_a_o = '0;
    we_b_o    = 1'b0;
    waddr_b_o = '0;
    wdata_b_o = '0;
    if (alu_valid_i) begin
      we_a_o    = 1'b1;
      waddr_a_o = alu_waddr_i;
      wdata_a_o = alu_wdata_i;
    end else if (drain_a) begin
      we_a_o    = 1'b1;
      waddr_a_o = tag_q[drain_ptr_q];
      wdata_a_o = data_q[drain_ptr_q];
    end
    if (pinc_valid_i) begin
      we_b_o    = 1'b1;
      waddr_b_o = pinc_waddr_i;
      wdata_b_o = pinc_wdata_i;
    end else if (drain_b) begin
      we_b_o    = 1'b1;
      waddr_b_o = tag_q[drain_ptr_q];
      wdata_b_o = data_q[drain_ptr_q];
    end
  end

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Bench for rf_writeback_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a queue model.
module tb_rf_writeback_ctrl;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic          alu_valid;
  logic [AW-1:0] alu_waddr;
  logic [DW-1:0] alu_wdata;
  logic          pinc_valid;
  logic [AW-1:0] pinc_waddr;
  logic [DW-1:0] pinc_wdata;
  logic          ld_issue;
  logic [AW-1:0] ld_waddr;
  logic          ld_issue_ready;
  logic          ld_rvalid;
  logic [DW-1:0] ld_rdata;
  logic [AW-1:0] raddr_a;
  logic [AW-1:0] raddr_b;
  logic          busy_a;
  logic          busy_b;
  logic [AW-1:0] waddr_a;
  logic [DW-1:0] wdata_a;
  logic          we_a;
  logic [AW-1:0] waddr_b;
  logic [DW-1:0] wdata_b;
  logic          we_b;
  logic          ld_err;

  rf_writeback_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LD_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid_i(alu_valid), .alu_waddr_i(alu_waddr), .alu_wdata_i(alu_wdata),
    .pinc_valid_i(pinc_valid), .pinc_waddr_i(pinc_waddr), .pinc_wdata_i(pinc_wdata),
    .ld_issue_i(ld_issue), .ld_waddr_i(ld_waddr), .ld_issue_ready_o(ld_issue_ready),
    .ld_rvalid_i(ld_rvalid), .ld_rdata_i(ld_rdata),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b), .busy_a_o(busy_a), .busy_b_o(busy_b),
    .waddr_a_o(waddr_a), .wdata_a_o(wdata_a), .we_a_o(we_a),
    .waddr_b_o(waddr_b), .wdata_b_o(wdata_b), .we_b_o(we_b),
    .ld_err_o(ld_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: outstanding loads in issue order
  typedef struct {
    logic [AW-1:0] tag;
    logic [DW-1:0] data;
    bit            filled;
  } ent_t;
  ent_t mq[$];
  bit   m_err;

  function automatic bit m_busy(input logic [AW-1:0] a);
    foreach (mq[i]) if (mq[i].tag == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_first_unfilled();
    foreach (mq[i]) if (!mq[i].filled) return i;
    return -1;
  endfunction

  // Register file image, B written last so it wins on equal addresses
  logic [DW-1:0] tb_rf [32];
  always @(posedge clk) begin
    if (we_a) tb_rf[waddr_a] = wdata_a;
    if (we_b) tb_rf[waddr_b] = wdata_b;
  end

  // Compare process: every cycle, expected outputs from the model, then advance it
  always @(negedge clk) begin
    bit            e_ready, head_ok, d_a, d_b;
    bit            e_we_a, e_we_b;
    logic [AW-1:0] e_wa_a, e_wa_b;
    logic [DW-1:0] e_wd_a, e_wd_b;
    int            fi;
    if (!rst_n) begin
      mq.delete();
      m_err = 1'b0;
    end
    e_ready = (mq.size() < DEPTH);
    head_ok = (mq.size() > 0) && mq[0].filled;
    d_a = head_ok && !alu_valid;
    d_b = head_ok && alu_valid && !pinc_valid;
    e_we_a = 0; e_wa_a = '0; e_wd_a = '0;
    e_we_b = 0; e_wa_b = '0; e_wd_b = '0;
    if (alu_valid) begin
      e_we_a = 1; e_wa_a = alu_waddr; e_wd_a = alu_wdata;
    end else if (d_a) begin
      e_we_a = 1; e_wa_a = mq[0].tag; e_wd_a = mq[0].data;
    end
    if (pinc_valid) begin
      e_we_b = 1; e_wa_b = pinc_waddr; e_wd_b = pinc_wdata;
    end else if (d_b) begin
      e_we_b = 1; e_wa_b = mq[0].tag; e_wd_b = mq[0].data;
    end
    chk("we_a", we_a, e_we_a);
    chk("waddr_a", waddr_a, e_wa_a);
    chk("wdata_a", wdata_a, e_wd_a);
    chk("we_b", we_b, e_we_b);
    chk("waddr_b", waddr_b, e_wa_b);
    chk("wdata_b", wdata_b, e_wd_b);
    chk("busy_a", busy_a, m_busy(raddr_a));
    chk("busy_b", busy_b, m_busy(raddr_b));
    chk("ready", ld_issue_ready, e_ready);
    chk("ld_err", ld_err, m_err);
    if (rst_n) begin
      fi = m_first_unfilled();
      if (ld_issue && !e_ready) m_err = 1'b1;
      if (ld_rvalid && fi < 0)  m_err = 1'b1;
      if (ld_rvalid && fi >= 0) begin
        mq[fi].filled = 1'b1;
        mq[fi].data   = ld_rdata;
      end
      if (d_a || d_b) void'(mq.pop_front());
      if (ld_issue && e_ready) mq.push_back('{tag: ld_waddr, data: '0, filled: 1'b0});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; alu_waddr = '0; alu_wdata = '0;
    pinc_valid = 0; pinc_waddr = '0; pinc_wdata = '0;
    ld_issue = 0; ld_waddr = '0; ld_rvalid = 0; ld_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle();
    tick();
    tick();
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    raddr_a = '0;
    raddr_b = '0;
    idle();
    foreach (tb_rf[i]) tb_rf[i] = '0;

    // 1: reset state, scoreboard clear for every address
    tick();
    @(negedge clk);
    chk("t1_we_a_rst", we_a, 0);
    chk("t1_ready_rst", ld_issue_ready, 1);
    chk("t1_err_rst", ld_err, 0);
    tick();
    rst_n = 1;
    for (int a = 0; a < 32; a++) begin
      raddr_a = AW'(a);
      raddr_b = AW'(31 - a);
      @(negedge clk);
      chk("t1_busy_a", busy_a, 0);
      chk("t1_busy_b", busy_b, 0);
      tick();
    end

    // 2: single load to r5, return at cycle 3, write at cycle 4
    ld_issue = 1; ld_waddr = 5; raddr_a = 5;
    @(negedge clk); chk("t2_busy_c0", busy_a, 0); tick();
    ld_issue = 0;
    @(negedge clk); chk("t2_busy_c1", busy_a, 1); tick();
    tick();
    ld_rvalid = 1; ld_rdata = 32'hCAFE0001;
    @(negedge clk); chk("t2_we_c3", we_a, 0); tick();
    ld_rvalid = 0;
    @(negedge clk);
    chk("t2_we_c4", we_a, 1);
    chk("t2_waddr_c4", waddr_a, 5);
    chk("t2_wdata_c4", wdata_a, 32'hCAFE0001);
    chk("t2_busy_c4", busy_a, 1);
    tick();
    @(negedge clk); chk("t2_busy_c5", busy_a, 0); tick();

    // 3: returns blocked while ALU and post-increment both write
    ld_issue = 1; ld_waddr = 7; raddr_a = 7; raddr_b = 6;
    tick();
    ld_issue = 1; ld_waddr = 6;
    alu_valid = 1; alu_waddr = 1; alu_wdata = 32'h11;
    pinc_valid = 1; pinc_waddr = 2; pinc_wdata = 32'h22;
    tick();
    ld_issue = 0; ld_rvalid = 1; ld_rdata = 32'h77;
    tick();
    ld_rdata = 32'h66;
    @(negedge clk); chk("t3_blk0_waddr_b", waddr_b, 2); tick();
    ld_rvalid = 0;
    @(negedge clk); chk("t3_blk1_busy", busy_a, 1); tick();
    @(negedge clk); chk("t3_blk2_waddr_a", waddr_a, 1); tick();
    pinc_valid = 0;
    @(negedge clk);
    chk("t3_portb_waddr", waddr_b, 7);
    chk("t3_portb_wdata", wdata_b, 32'h77);
    tick();
    alu_valid = 0;
    @(negedge clk);
    chk("t3_porta_waddr", waddr_a, 6);
    chk("t3_porta_wdata", wdata_a, 32'h66);
    chk("t3_portb_idle", we_b, 0);
    tick();
    @(negedge clk); chk("t3_busy7_clr", busy_a, 0); chk("t3_busy6_clr", busy_b, 0); tick();

    // 4: fill the queue, overflow issue, then four in-order returns
    raddr_a = 4; raddr_b = 9;
    for (int k = 0; k < DEPTH; k++) begin
      ld_issue = 1; ld_waddr = AW'(k + 1);
      tick();
    end
    ld_waddr = 9;
    @(negedge clk); chk("t4_ready_full", ld_issue_ready, 0); tick();
    ld_issue = 0;
    for (int k = 0; k <= DEPTH; k++) begin
      ld_rvalid = (k < DEPTH);
      ld_rdata  = 32'hD0 + k + 1;
      @(negedge clk);
      if (k == 0) begin
        chk("t4_err_ovf", ld_err, 1);
        chk("t4_busy9", busy_b, 0);
      end else begin
        chk("t4_order_waddr", waddr_a, k);
        chk("t4_order_wdata", wdata_a, 32'hD0 + k);
      end
      tick();
    end
    ld_rvalid = 0;
    @(negedge clk); chk("t4_empty_ready", ld_issue_ready, 1); tick();

    // 5: return on empty queue; same-address ALU + post-increment
    do_reset();
    @(negedge clk); chk("t5_err_cleared", ld_err, 0); tick();
    ld_rvalid = 1; ld_rdata = 32'h1234;
    @(negedge clk); chk("t5_no_write", we_a, 0); tick();
    ld_rvalid = 0;
    alu_valid = 1; alu_waddr = 3; alu_wdata = 32'hAAAA;
    pinc_valid = 1; pinc_waddr = 3; pinc_wdata = 32'hBBBB;
    @(negedge clk);
    chk("t5_err_set", ld_err, 1);
    chk("t5_we_a", we_a, 1);
    chk("t5_we_b", we_b, 1);
    tick();
    idle();
    @(negedge clk);
    chk("t5_rf3", tb_rf[3], 32'hBBBB);
    chk("t5_err_sticky", ld_err, 1);
    tick();

    // 6: reset with two loads outstanding
    do_reset();
    raddr_a = 10; raddr_b = 11;
    ld_issue = 1; ld_waddr = 10; tick();
    ld_waddr = 11; tick();
    ld_issue = 0;
    @(negedge clk); chk("t6_busy_pre", busy_a, 1); tick();
    rst_n = 0;
    @(negedge clk);
    chk("t6_busy_a_rst", busy_a, 0);
    chk("t6_busy_b_rst", busy_b, 0);
    chk("t6_ready_rst", ld_issue_ready, 1);
    tick();
    rst_n = 1;
    ld_rvalid = 1; ld_rdata = 32'h5555;
    @(negedge clk); chk("t6_we_a", we_a, 0); tick();
    ld_rvalid = 0;
    @(negedge clk); chk("t6_err", ld_err, 1); tick();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 0;
        idle();
      end else begin
        rst_n = 1;
        ld_issue  = ($urandom_range(0, 2) == 0);
        ld_waddr  = AW'($urandom_range(0, 7));
        ld_rdata  = $urandom;
        ld_rvalid = (m_first_unfilled() >= 0) ? ($urandom_range(0, 1) == 1)
                                              : ($urandom_range(0, 49) == 0);
        alu_valid  = ($urandom_range(0, 1) == 1);
        alu_waddr  = AW'($urandom_range(0, 7));
        alu_wdata  = $urandom;
        pinc_valid = ($urandom_range(0, 4) < 2);
        pinc_waddr = AW'($urandom_range(0, 7));
        pinc_wdata = $urandom;
        if (m_busy(alu_waddr))  alu_valid  = 0;
        if (m_busy(pinc_waddr)) pinc_valid = 0;
      end
      raddr_a = AW'($urandom_range(0, 7));
      raddr_b = AW'($urandom_range(0, 7));
      tick();
    end
    rst_n = 1;
    idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
